// File: rtl/sync_fifo_mem_if.sv
// Handshake/status bundle for sync_fifo_mem: the producer/consumer side drives
// through master, the FIFO itself connects through slave.
interface sync_fifo_mem_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 7
);
    logic [DATA_W-1:0] wrt_data;
    logic              wrt_en;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wrt_data, wrt_en, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wrt_data, wrt_en, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO over a 2^ADDR_W x DATA_W array: registered read data with a
// valid strobe, count-decoded status flags and sticky overflow/underflow flags.
module sync_fifo_mem #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned AF_LEVEL = 120,
    parameter int unsigned AE_LEVEL = 8
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_mem_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = CNT_ONE[ADDR_W-1:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_w;
    logic              empty_w;
    logic              wr_acc;
    logic              rd_acc;

    // Flags decode the registered count, so accepts see only pre-edge state.
    always_comb begin
        full_w  = (count_q == CNT_FULL);
        empty_w = (count_q == '0);
        wr_acc  = bus.wrt_en & ~full_w;
        rd_acc  = bus.rd_en & ~empty_w;
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= bus.wrt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_data_q <= mem[rd_ptr];
            end
            rd_valid_q <= rd_acc;

            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            // A new error event wins over a clear in the same cycle.
            if (bus.wrt_en && full_w) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (32'(count_q) >= AF_LEVEL);
    assign bus.almost_empty = (32'(count_q) <= AE_LEVEL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
